// File: rtl/mpu6050_pkg.sv
// Shared constants and types for the MPU6050 poll sequencer.
package mpu6050_pkg;

   // MPU6050 register map entries touched by the sequencer
   localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
   localparam logic [7:0] REG_SMPLRT_DIV   = 8'h19;
   localparam logic [7:0] REG_CONFIG       = 8'h1A;
   localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;

   // 14 measurement bytes: accel xyz, temp, gyro xyz, each {hi,lo}
   localparam int         BURST_LEN      = 14;
   localparam logic [3:0] LAST_POLL_IDX  = 4'(BURST_LEN - 1);
   localparam logic [1:0] LAST_INIT_STEP = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT     = 3'd2,
      ST_EVAL     = 3'd3,
      ST_POLL_GAP = 3'd4,
      ST_PUBLISH  = 3'd5,
      ST_FAULT    = 3'd6
   } seq_state_t;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_NACK    = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;

   // Register address of burst byte idx
   function automatic logic [7:0] poll_reg(input logic [3:0] idx);
      return REG_ACCEL_XOUT_H + {4'h0, idx};
   endfunction

endpackage

// File: rtl/mpu6050_poll_sequencer_i2c_txn_handshake.sv
// Enable/busy handshake with the single-byte I2C master plus the per-phase
// timeout counter. The sequencer owns the state; this block turns the
// ISSUE/WAIT/EVAL phase flags into enable, progress and fault indications.
module i2c_txn_handshake #(
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_issue,
   input  logic       i_wait,
   input  logic       i_eval,
   input  logic       i_busy,
   input  logic       i_ack_error,
   input  logic [7:0] i_data_rd,
   output logic       o_enable,
   output logic       o_accepted,
   output logic       o_complete,
   output logic       o_nack,
   output logic       o_timeout,
   output logic [7:0] o_rdata
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_phase_cnt;
   logic          w_stalled;

   // enable is purely a function of the phase, so it can never be high in
   // WAIT and falls immediately when reset forces the sequencer to IDLE
   assign o_enable   = i_issue;
   assign o_accepted = i_issue & i_busy;
   assign o_complete = i_wait & ~i_busy;
   assign w_stalled  = (i_issue | i_wait) & ~o_accepted & ~o_complete;
   // fires on the last allowed cycle of a phase so FAULT follows after
   // exactly TIMEOUT_CYCLES cycles in that phase
   assign o_timeout  = w_stalled & (r_phase_cnt == LAST_CNT);

   // ack/data are only meaningful during the single EVAL cycle
   assign o_nack  = i_eval & i_ack_error;
   assign o_rdata = i_eval ? i_data_rd : 8'h00;

   // phase counter: counts stalled cycles, clears on any phase change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_phase_cnt <= '0;
      else if (w_stalled) r_phase_cnt <= r_phase_cnt + 1'b1;
      else                r_phase_cnt <= '0;
   end

endmodule

// File: rtl/mpu6050_poll_sequencer.sv
// MPU6050 command sequencer: init writes, then periodic 14-byte burst poll
// assembled into seven 16-bit samples and published atomically. NACKs are
// retried; retry exhaustion or a hung master ends in a sticky FAULT.
module mpu6050_poll_sequencer
   import mpu6050_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR     = 7'h68,
   parameter logic [7:0] SMPLRT_DIV_VAL = 8'h07,
   parameter logic [7:0] CONFIG_VAL     = 8'h03,
   parameter int         POLL_PERIOD    = 500_000,
   parameter int         MAX_RETRY      = 3,
   parameter int         TIMEOUT_CYCLES = 100_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop_req,
   output logic        i2c_enable,
   output logic        i2c_rw,
   output logic [6:0]  i2c_slave_addr,
   output logic [7:0]  i2c_reg_addr,
   output logic [7:0]  i2c_data_wr,
   input  logic        i2c_busy,
   input  logic        i2c_ack_error,
   input  logic [7:0]  i2c_data_rd,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic [15:0] temp,
   output logic [15:0] gyro_x,
   output logic [15:0] gyro_y,
   output logic [15:0] gyro_z,
   output logic        sample_valid,
   output logic        running,
   output logic        fault,
   output logic [1:0]  fault_code
);

   localparam int            PW            = $clog2(POLL_PERIOD + 1);
   localparam logic [PW-1:0] PERIOD_RELOAD = PW'(POLL_PERIOD - 1);
   localparam int            RW            = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_LIMIT   = RW'(MAX_RETRY);

   seq_state_t      r_state, w_state_nxt;
   logic            r_init_mode, w_init_mode_nxt;
   logic [1:0]      r_init_step, w_init_step_nxt;
   logic [3:0]      r_idx, w_idx_nxt;
   logic [RW-1:0]   r_retry, w_retry_nxt;
   logic            r_fault, w_fault_nxt;
   logic [1:0]      r_fault_code, w_fault_code_nxt;
   logic [PW-1:0]   r_period;
   logic            w_period_load;
   logic            w_stage_we;
   logic            w_publish;
   logic [6:0][15:0] r_stage, r_sample, w_stage_full;

   logic            w_in_txn;
   logic            w_cmd_rw;
   logic [7:0]      w_cmd_reg, w_cmd_data;
   logic            w_accepted, w_complete, w_nack, w_timeout;
   logic [7:0]      w_rdata;

   i2c_txn_handshake #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_hs (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_issue     (r_state == ST_ISSUE),
      .i_wait      (r_state == ST_WAIT),
      .i_eval      (r_state == ST_EVAL),
      .i_busy      (i2c_busy),
      .i_ack_error (i2c_ack_error),
      .i_data_rd   (i2c_data_rd),
      .o_enable    (i2c_enable),
      .o_accepted  (w_accepted),
      .o_complete  (w_complete),
      .o_nack      (w_nack),
      .o_timeout   (w_timeout),
      .o_rdata     (w_rdata)
   );

   // current command from init table or burst index
   always_comb begin
      w_cmd_rw   = ~r_init_mode;
      w_cmd_reg  = poll_reg(r_idx);
      w_cmd_data = 8'h00;
      if (r_init_mode) begin
         case (r_init_step)
            2'd0:    begin w_cmd_reg = REG_PWR_MGMT_1; w_cmd_data = 8'h00;          end
            2'd1:    begin w_cmd_reg = REG_SMPLRT_DIV; w_cmd_data = SMPLRT_DIV_VAL; end
            default: begin w_cmd_reg = REG_CONFIG;     w_cmd_data = CONFIG_VAL;     end
         endcase
      end
   end

   // command fields are held through ISSUE/WAIT/EVAL and zero otherwise
   assign w_in_txn       = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_EVAL);
   assign i2c_rw         = w_in_txn & w_cmd_rw;
   assign i2c_reg_addr   = w_in_txn ? w_cmd_reg  : 8'h00;
   assign i2c_data_wr    = w_in_txn ? w_cmd_data : 8'h00;
   assign i2c_slave_addr = SLAVE_ADDR;

   assign running      = (r_state != ST_IDLE) && (r_state != ST_FAULT);
   assign sample_valid = (r_state == ST_PUBLISH);
   assign fault        = r_fault;
   assign fault_code   = r_fault_code;

   assign accel_x = r_sample[0];
   assign accel_y = r_sample[1];
   assign accel_z = r_sample[2];
   assign temp    = r_sample[3];
   assign gyro_x  = r_sample[4];
   assign gyro_y  = r_sample[5];
   assign gyro_z  = r_sample[6];

   // sequencer state and bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_init_mode  <= 1'b0;
         r_init_step  <= 2'd0;
         r_idx        <= 4'd0;
         r_retry      <= '0;
         r_fault      <= 1'b0;
         r_fault_code <= FC_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_init_mode  <= w_init_mode_nxt;
         r_init_step  <= w_init_step_nxt;
         r_idx        <= w_idx_nxt;
         r_retry      <= w_retry_nxt;
         r_fault      <= w_fault_nxt;
         r_fault_code <= w_fault_code_nxt;
      end
   end

   // next-state: handshake phases, retry/fault policy, init/poll stepping
   always_comb begin
      w_state_nxt      = r_state;
      w_init_mode_nxt  = r_init_mode;
      w_init_step_nxt  = r_init_step;
      w_idx_nxt        = r_idx;
      w_retry_nxt      = r_retry;
      w_fault_nxt      = r_fault;
      w_fault_code_nxt = r_fault_code;
      w_period_load    = 1'b0;
      w_stage_we       = 1'b0;
      w_publish        = 1'b0;
      case (r_state)
         ST_IDLE, ST_FAULT: begin
            if (start) begin
               w_state_nxt      = ST_ISSUE;
               w_init_mode_nxt  = 1'b1;
               w_init_step_nxt  = 2'd0;
               w_idx_nxt        = 4'd0;
               w_retry_nxt      = '0;
               w_fault_nxt      = 1'b0;
               w_fault_code_nxt = FC_NONE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (w_timeout) begin
               w_state_nxt      = ST_FAULT;
               w_fault_nxt      = 1'b1;
               w_fault_code_nxt = FC_TIMEOUT;
            end else if (w_accepted) begin
               w_state_nxt = ST_WAIT;
            end else if (w_complete) begin
               w_state_nxt = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (w_nack) begin
               if (r_retry < RETRY_LIMIT) begin
                  w_retry_nxt = r_retry + 1'b1;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_state_nxt      = ST_FAULT;
                  w_fault_nxt      = 1'b1;
                  w_fault_code_nxt = FC_NACK;
               end
            end else begin
               w_retry_nxt = '0;
               w_stage_we  = ~r_init_mode;
               if (stop_req) begin
                  // transaction boundary; partial staging is simply dropped
                  w_state_nxt = ST_IDLE;
               end else if (r_init_mode) begin
                  w_state_nxt = ST_ISSUE;
                  if (r_init_step == LAST_INIT_STEP) begin
                     // init done: first poll starts at once and opens a period
                     w_init_mode_nxt = 1'b0;
                     w_idx_nxt       = 4'd0;
                     w_period_load   = 1'b1;
                  end else begin
                     w_init_step_nxt = r_init_step + 2'd1;
                  end
               end else if (r_idx == LAST_POLL_IDX) begin
                  w_state_nxt = ST_PUBLISH;
                  w_publish   = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + 4'd1;
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_PUBLISH: begin
            w_state_nxt = ST_POLL_GAP;
            w_idx_nxt   = 4'd0;
         end
         ST_POLL_GAP: begin
            if (stop_req) begin
               w_state_nxt = ST_IDLE;
            end else if (r_period == '0) begin
               // an overrun poll leaves the timer at 0, so the next starts now
               w_state_nxt   = ST_ISSUE;
               w_period_load = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // period timer: reload at each poll start, saturating countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_period <= '0;
      else if (w_period_load)   r_period <= PERIOD_RELOAD;
      else if (r_period != '0)  r_period <= r_period - 1'b1;
   end

   // staging including the byte arriving this cycle, for same-edge publish
   always_comb begin
      w_stage_full       = r_stage;
      w_stage_full[6][7:0] = w_rdata;
   end

   // staging fill (even=hi, odd=lo) and atomic copy to published outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage  <= '0;
         r_sample <= '0;
      end else begin
         if (w_stage_we) begin
            if (r_idx[0]) r_stage[r_idx[3:1]][7:0]  <= w_rdata;
            else          r_stage[r_idx[3:1]][15:8] <= w_rdata;
         end
         if (w_publish) r_sample <= w_stage_full;
      end
   end

endmodule

// File: tb/tb_mpu6050_poll_sequencer.sv
// Directed bench: MPU6050 slave/master model, transaction log, table checks.
module tb_mpu6050_poll_sequencer;

   localparam int PERIOD = 5000;
   localparam int TMO    = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop_req = 1'b0;
   logic        i2c_enable, i2c_rw;
   logic [6:0]  i2c_slave_addr;
   logic [7:0]  i2c_reg_addr, i2c_data_wr;
   logic        i2c_busy;
   logic        i2c_ack_error;
   logic [7:0]  i2c_data_rd;
   logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
   logic        sample_valid, running, fault;
   logic [1:0]  fault_code;

   always #5 clk = ~clk;

   mpu6050_poll_sequencer #(
      .SLAVE_ADDR     (7'h68),
      .SMPLRT_DIV_VAL (8'h07),
      .CONFIG_VAL     (8'h03),
      .POLL_PERIOD    (PERIOD),
      .MAX_RETRY      (3),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .stop_req       (stop_req),
      .i2c_enable     (i2c_enable),
      .i2c_rw         (i2c_rw),
      .i2c_slave_addr (i2c_slave_addr),
      .i2c_reg_addr   (i2c_reg_addr),
      .i2c_data_wr    (i2c_data_wr),
      .i2c_busy       (i2c_busy),
      .i2c_ack_error  (i2c_ack_error),
      .i2c_data_rd    (i2c_data_rd),
      .accel_x        (accel_x),
      .accel_y        (accel_y),
      .accel_z        (accel_z),
      .temp           (temp),
      .gyro_x         (gyro_x),
      .gyro_y         (gyro_y),
      .gyro_z         (gyro_z),
      .sample_valid   (sample_valid),
      .running        (running),
      .fault          (fault),
      .fault_code     (fault_code)
   );

   typedef struct { logic rw; logic [7:0] ra; logic [7:0] wd; } txn_t;
   typedef struct { string nm; logic [15:0] v; } smp_t;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   sv_cnt = 0;
   int   wait_n = 0;
   txn_t log_q[$];
   int   poll_start_q[$];
   txn_t exp_txn[17];
   smp_t exp_smp[7];

   // model knobs
   logic       stuck = 1'b0;
   logic [7:0] nack_reg = 8'h00;
   int         nack_left = 0;
   logic [7:0] mask = 8'h00;

   logic       m_busy;
   logic [2:0] m_cnt;
   logic       m_nack;
   logic [7:0] m_ra;

   assign i2c_busy = m_busy | stuck;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (rst_n && sample_valid) sv_cnt++;

   // master+slave model: accept on enable, busy for 4 cycles, data = reg ^ mask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy        <= 1'b0;
         m_cnt         <= 3'd0;
         m_nack        <= 1'b0;
         m_ra          <= 8'h00;
         i2c_ack_error <= 1'b0;
         i2c_data_rd   <= 8'h00;
      end else if (!m_busy) begin
         if (i2c_enable && !stuck) begin
            m_busy <= 1'b1;
            m_cnt  <= 3'd3;
            m_ra   <= i2c_reg_addr;
            log_q.push_back('{i2c_rw, i2c_reg_addr, i2c_data_wr});
            if (i2c_rw && i2c_reg_addr == 8'h3B) poll_start_q.push_back(cyc);
            if (i2c_reg_addr == nack_reg && nack_left > 0) begin
               m_nack <= 1'b1;
               nack_left--;
            end else begin
               m_nack <= 1'b0;
            end
         end
      end else if (m_cnt == 3'd0) begin
         m_busy        <= 1'b0;
         i2c_ack_error <= m_nack;
         i2c_data_rd   <= m_ra ^ mask;
      end else begin
         m_cnt <= m_cnt - 3'd1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit cond(input int w);
      case (w)
         0:       return bit'(sample_valid);
         1:       return bit'(!running);
         2:       return bit'(fault);
         3:       return log_q.size() >= wait_n;
         4:       return bit'(running && i2c_busy && !i2c_enable);
         5:       return poll_start_q.size() >= wait_n;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string nm, input int w, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (cond(w)) break;
         @(negedge clk);
      end
      n_chk++;
      if (!cond(w)) begin
         n_err++;
         $display("FAIL wait_%s: condition not reached within %0d cycles", nm, lim);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [15:0] out_val(input int i);
      case (i)
         0: return accel_x;
         1: return accel_y;
         2: return accel_z;
         3: return temp;
         4: return gyro_x;
         5: return gyro_y;
         default: return gyro_z;
      endcase
   endfunction

   function automatic int count_reg(input logic [7:0] ra);
      int c = 0;
      foreach (log_q[k]) if (log_q[k].ra == ra) c++;
      return c;
   endfunction

   initial begin
      int n;
      logic [7:0] a;

      exp_txn[0] = '{1'b0, 8'h6B, 8'h00};
      exp_txn[1] = '{1'b0, 8'h19, 8'h07};
      exp_txn[2] = '{1'b0, 8'h1A, 8'h03};
      a = 8'h3B;
      for (int i = 0; i < 14; i++) begin
         exp_txn[3+i] = '{1'b1, a, 8'h00};
         a = a + 8'd1;
      end
      exp_smp[0] = '{"accel_x", 16'h3B3C};
      exp_smp[1] = '{"accel_y", 16'h3D3E};
      exp_smp[2] = '{"accel_z", 16'h3F40};
      exp_smp[3] = '{"temp",    16'h4142};
      exp_smp[4] = '{"gyro_x",  16'h4344};
      exp_smp[5] = '{"gyro_y",  16'h4546};
      exp_smp[6] = '{"gyro_z",  16'h4748};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_enable", 32'(i2c_enable), 32'h0);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_fault_code", 32'(fault_code), 32'h0);
      chk("rst_sample_valid", 32'(sample_valid), 32'h0);
      chk("rst_reg_addr", 32'(i2c_reg_addr), 32'h0);
      chk("rst_accel_x", 32'(accel_x), 32'h0);
      chk("slave_addr", 32'(i2c_slave_addr), 32'h68);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // init + first poll
      pulse_start();
      chk("running_after_start", 32'(running), 32'h1);
      wait_for("sv1", 0, 1000);
      for (int i = 0; i < 7; i++) chk(exp_smp[i].nm, 32'(out_val(i)), 32'(exp_smp[i].v));
      @(negedge clk);
      chk("sv_one_cycle", 32'(sample_valid), 32'h0);
      chk("txn_count", 32'(log_q.size() >= 17), 32'h1);
      for (int i = 0; i < 17; i++) begin
         if (i < log_q.size()) begin
            chk($sformatf("txn%0d_rw", i), 32'(log_q[i].rw), 32'(exp_txn[i].rw));
            chk($sformatf("txn%0d_reg", i), 32'(log_q[i].ra), 32'(exp_txn[i].ra));
            chk($sformatf("txn%0d_wd", i), 32'(log_q[i].wd), 32'(exp_txn[i].wd));
         end
      end

      // second poll, period spacing
      wait_for("sv2", 0, PERIOD + 1000);
      n_chk++;
      if (poll_start_q.size() < 2) begin
         n_err++;
         $display("FAIL poll_period: got %0d poll starts expected 2", poll_start_q.size());
      end else begin
         chk("poll_period", 32'(poll_start_q[1] - poll_start_q[0]), 32'(PERIOD));
      end
      mask = 8'hFF;
      @(negedge clk);

      // stop during read index 6 of the third poll
      wait_n = 17 + 14 + 7;
      wait_for("idx6", 3, PERIOD + 1000);
      stop_req = 1'b1;
      wait_for("stop_idle", 1, 200);
      chk("stop_txn_count", 32'(log_q.size()), 32'(17 + 14 + 7));
      chk("stop_last_reg", 32'(log_q[log_q.size()-1].ra), 32'h41);
      chk("stop_no_publish", 32'(sv_cnt), 32'd2);
      chk("stop_keep_accel_x", 32'(accel_x), 32'h3B3C);
      chk("stop_keep_gyro_z", 32'(gyro_z), 32'h4748);
      chk("stop_no_fault", 32'(fault), 32'h0);
      stop_req = 1'b0;
      mask = 8'h00;
      @(negedge clk);

      // 0x19 NACKed twice then ACKed
      log_q.delete();
      poll_start_q.delete();
      nack_reg = 8'h19;
      nack_left = 2;
      pulse_start();
      wait_n = 1;
      wait_for("retry_poll", 5, 500);
      chk("retry_attempts", 32'(count_reg(8'h19)), 32'd3);
      chk("retry_no_fault", 32'(fault), 32'h0);
      chk("retry_next_reg", 32'(log_q[4].ra), 32'h1A);
      stop_req = 1'b1;
      wait_for("retry_stop", 1, 200);
      stop_req = 1'b0;

      // persistent NACK -> fault 01
      log_q.delete();
      nack_left = 1000;
      pulse_start();
      wait_for("nack_fault", 2, 500);
      chk("nack_fault_code", 32'(fault_code), 32'h1);
      chk("nack_attempts", 32'(count_reg(8'h19)), 32'd4);
      chk("nack_running", 32'(running), 32'h0);
      n = log_q.size();
      repeat (50) @(negedge clk);
      chk("nack_quiet", 32'(log_q.size()), 32'(n));
      chk("nack_enable", 32'(i2c_enable), 32'h0);
      nack_left = 0;

      // busy stuck high -> timeout after TMO cycles of WAIT
      log_q.delete();
      stuck = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("tmo_fault_cleared", 32'(fault), 32'h0);
      chk("tmo_issue_enable", 32'(i2c_enable), 32'h1);
      n = 0;
      @(negedge clk);
      while (!fault && n < 1000) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_wait_cycles", 32'(n), 32'(TMO));
      chk("tmo_fault_code", 32'(fault_code), 32'h2);
      chk("tmo_enable", 32'(i2c_enable), 32'h0);
      stuck = 1'b0;
      @(negedge clk);
      pulse_start();
      chk("restart_fault", 32'(fault), 32'h0);
      chk("restart_fault_code", 32'(fault_code), 32'h0);
      wait_n = 1;
      wait_for("restart_txn", 3, 100);
      chk("restart_first_reg", 32'(log_q[0].ra), 32'h6B);

      // async reset during WAIT
      wait_for("mid_wait", 4, 100);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_enable", 32'(i2c_enable), 32'h0);
      chk("arst_running", 32'(running), 32'h0);
      chk("arst_accel_x", 32'(accel_x), 32'h0);
      chk("arst_reg_addr", 32'(i2c_reg_addr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      n = log_q.size();
      repeat (30) @(negedge clk);
      chk("arst_quiet", 32'(log_q.size()), 32'(n));
      chk("arst_idle", 32'(running), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mpu6050_poll_sequencer.md
Name: mpu6050_poll_sequencer

Overview:
Command sequencer that owns the single-byte I2C master (enable/rw/slave_addr/reg_addr/data_wr → busy/data_rd/ack_error). After start it runs a fixed MPU6050 init write sequence, then periodically burst-polls the 14 measurement registers 0x3B..0x48 one byte per transaction. It assembles seven 16-bit samples and publishes them atomically. It retries NACKed transactions and faults on retry exhaustion or master hang.

Parameters:
SLAVE_ADDR, 7'h68, MPU6050 7-bit address
SMPLRT_DIV_VAL, 8'h07, value written to reg 0x19
CONFIG_VAL, 8'h03, value written to reg 0x1A (DLPF)
POLL_PERIOD, 500_000, clk cycles from one poll start to the next (≥ 1)
MAX_RETRY, 3, retries per transaction after the first attempt
TIMEOUT_CYCLES, 100_000, max cycles in any single handshake phase

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE or FAULT and begins init
stop_req  in  1  level; return to IDLE at next transaction boundary
i2c_enable  out  1  request to master
i2c_rw  out  1  1=read, 0=write
i2c_slave_addr  out  7  always SLAVE_ADDR
i2c_reg_addr  out  8  target register
i2c_data_wr  out  8  write data
i2c_busy  in  1  master busy
i2c_ack_error  in  1  master NACK flag
i2c_data_rd  in  8  master read byte
accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z  out  16 each  published sample ({hi,lo})
sample_valid  out  1  one-cycle pulse on publish
running  out  1  high outside IDLE/FAULT
fault  out  1  sticky until start or reset
fault_code  out  2  01=NACK exhausted, 10=timeout, 00=none

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. i2c_slave_addr is constant SLAVE_ADDR.
- States: IDLE, ISSUE, WAIT, EVAL, POLL_GAP, PUBLISH, FAULT.
- Handshake, shared by all transactions:
  - ISSUE drives i2c_enable=1 with stable rw/reg_addr/data_wr until i2c_busy=1 is sampled, then goes to WAIT with i2c_enable=0.
  - WAIT holds command fields until i2c_busy=0, then goes to EVAL.
  - EVAL samples i2c_ack_error and i2c_data_rd exactly once.
  - i2c_enable must never be high while in WAIT.
- Init list, in order, all writes: (0x6B,0x00), (0x19,SMPLRT_DIV_VAL), (0x1A,CONFIG_VAL). A 2-bit step index selects the entry.
- Poll: 14 reads, byte index 0..13, reg_addr = 0x3B + index.
  - Even index loads the high byte into staging; odd index loads the low byte.
  - Index 13 OK → PUBLISH.
- PUBLISH: copies staging to all seven outputs in the same cycle, pulses sample_valid for 1 cycle, then enters POLL_GAP.
- Period timer:
  - Loads POLL_PERIOD-1 when the first read of a poll (index 0) enters ISSUE. Also loads when init completes, and POLL_GAP then proceeds immediately.
  - Decrements every cycle, saturating at 0.
  - POLL_GAP leaves at 0 with index=0. If a poll overruns the period, the next poll starts immediately with no backlog accumulation.
- EVAL with ack_error=1:
  - If retry count < MAX_RETRY: increment it and re-ISSUE the same transaction.
  - Otherwise: FAULT, fault_code=01.
  - Retry count clears on every successful transaction.
- Timeout: a phase counter clears on entering ISSUE/WAIT. Reaching TIMEOUT_CYCLES in either state → FAULT, fault_code=10, i2c_enable=0.
- FAULT: fault=1, running=0, no I2C activity. start clears fault/fault_code and restarts init.
- stop_req: checked in EVAL (after successful completion) and in POLL_GAP → IDLE. A transaction in flight is never abandoned. A partially filled staging buffer is discarded and not published.
- start while running is ignored. Simultaneous start and stop_req in IDLE: start wins.
- Published outputs hold their last values across IDLE/FAULT; they reset only on rst_n.
- Reset mid-transaction drops i2c_enable at once. The master is reset by the same rst_n.

Decomposition:
- Package mpu6050_pkg: register address constants (PWR_MGMT_1=0x6B, SMPLRT_DIV=0x19, CONFIG=0x1A, ACCEL_XOUT_H=0x3B), burst length 14, state encoding, fault_code constants.
- One sub-module, i2c_txn_handshake: the ISSUE/WAIT/EVAL enable-busy protocol plus the timeout counter. It presents done/nack/timeout/rdata to the sequencer FSM.

Test Plan:
- MPU6050 slave model at 0x68 ACKs everything; start pulse → writes observed in order 0x6B=00, 0x19=07, 0x1A=03, then reads 0x3B..0x48; running=1.
- Model returns byte = register address → accel_x=0x3B3C, temp=0x4142, gyro_z=0x4748, sample_valid exactly 1 cycle; consecutive poll starts are POLL_PERIOD cycles apart (POLL_PERIOD=5000).
- Model NACKs the 0x19 write twice, then ACKs → exactly 3 attempts on 0x19, no fault, sequence continues. NACK persistently → 4 attempts (MAX_RETRY=3), then fault=1, fault_code=01, no further i2c_enable.
- i2c_busy stuck high (TIMEOUT_CYCLES=200) → FAULT with fault_code=10 at cycle 200 of WAIT; start pulse → fault clears, init restarts.
- stop_req raised during read index 6 → index 6 completes, IDLE, no sample_valid, outputs keep previous sample.
- rst_n asserted mid-WAIT → all outputs 0 immediately; after release, no I2C activity until start.
